// File: rtl/kyber_frame_rx_if.sv
// Link and consumer-side signals of the Kyber frame receiver.
// The master side is whoever drives the link and reads the buffer.
interface kyber_frame_rx_if #(
    parameter int DW = 32
);
    logic          start;
    logic          sel;
    logic [2:0]    k;
    logic          wen;
    logic [DW-1:0] din;
    logic          ready_pk;
    logic          ready_c;
    logic          req;
    logic          valid;
    logic [DW-1:0] dout;
    logic          err;

    modport master (
        output start, sel, k, wen, din, req,
        input  ready_pk, ready_c, valid, dout, err
    );

    modport slave (
        input  start, sel, k, wen, din, req,
        output ready_pk, ready_c, valid, dout, err
    );
endinterface

// File: rtl/kyber_frame_rx.sv
// Buffers one Kyber public-key or ciphertext frame from the link, then
// replays it word by word, in arrival order, to a consumer.
module kyber_frame_rx #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input logic             clk,
    input logic             rst,
    kyber_frame_rx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RECV, HOLD, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt, rd_cnt, len_q, len_d;
    logic          sel_q;
    logic          valid_q, err_q;
    logic [DW-1:0] dout_q;

    logic          k_legal, start_ok, bad_start, stray_wen;
    logic          wr_en, rd_en, last_wr, last_rd, holding;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Frame length in words for each (sel, k); 0 marks an illegal k.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        len_d = '0;
        case ({bus.sel, bus.k})
            4'b0_010: len_d = AW'(200);
            4'b0_011: len_d = AW'(296);
            4'b0_100: len_d = AW'(392);
            4'b1_010: len_d = AW'(192);
            4'b1_011: len_d = AW'(272);
            4'b1_100: len_d = AW'(392);
            default:  len_d = '0;
        endcase
    end

    assign k_legal   = (len_d != '0);
    assign holding   = (state_q == HOLD) || (state_q == DRAIN);
    assign start_ok  = (state_q == IDLE) && bus.start && k_legal;
    assign bad_start = (state_q == IDLE) && bus.start && !k_legal;
    assign wr_en     = (state_q == RECV) && bus.wen;
    assign rd_en     = holding && bus.req;
    assign last_wr   = wr_en && (wr_cnt == len_q - AW'(1));
    assign last_rd   = rd_en && (rd_cnt == len_q - AW'(1));
    // A wen arriving with an accepted start is silently dropped, not flagged.
    assign stray_wen = bus.wen && (state_q != RECV) && !start_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_ok) state_d = RECV;
            RECV:  if (last_wr)  state_d = HOLD;
            HOLD:  if (rd_en)    state_d = last_rd ? IDLE : DRAIN;
            DRAIN: if (last_rd)  state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            len_q   <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= rd_en;
            err_q   <= stray_wen || bad_start;
            if (start_ok) begin
                sel_q  <= bus.sel;
                len_q  <= len_d;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            if (wr_en) wr_cnt <= wr_cnt + AW'(1);
            if (rd_en) begin
                rd_cnt <= rd_cnt + AW'(1);
                dout_q <= mem[rd_cnt];
            end
        end
    end

    // NOTE: the buffer has no reset so it maps onto a plain synchronous RAM; stale contents are never read.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_cnt] <= bus.din;
    end

    assign bus.ready_pk = holding && !sel_q;
    assign bus.ready_c  = holding && sel_q;
    assign bus.valid    = valid_q;
    assign bus.dout     = dout_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_kyber_frame_rx.sv
// Directed bench for kyber_frame_rx: a table of frame types plus hand-written
// sequences for stray writes, mid-frame reset and consumer stalls.
module tb_kyber_frame_rx;
    localparam int DW = 32;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kyber_frame_rx_if #(.DW(DW)) bus ();

    kyber_frame_rx #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       sel;
        logic [2:0] k;
        bit         gaps;
        bit         exp_err;
        int         exp_len;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic sel, input logic [2:0] k);
        bus.start = 1'b1;
        bus.sel   = sel;
        bus.k     = k;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic write_frame(input int len, input logic [DW-1:0] base, input bit gaps, input logic sel);
        for (int i = 0; i < len; i++) begin
            bus.wen = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            bus.wen = 1'b1;
            bus.din = base + DW'(i);
            tick();
            if (i == len - 2) begin
                check("ready_pk early", DW'(bus.ready_pk), '0);
                check("ready_c early", DW'(bus.ready_c), '0);
            end
        end
        bus.wen = 1'b0;
        check("ready_pk after frame", DW'(bus.ready_pk), DW'(!sel));
        check("ready_c after frame", DW'(bus.ready_c), DW'(sel));
    endtask

    task automatic drain(input int len, input logic [DW-1:0] base, input int stall_at);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                bus.req = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("valid during stall", DW'(bus.valid), '0);
                    check("dout hold during stall", bus.dout, base + DW'(i - 1));
                end
            end
            bus.req = 1'b1;
            tick();
            check("drain valid", DW'(bus.valid), DW'(1));
            check("drain dout", bus.dout, base + DW'(i));
        end
        check("ready_pk after drain", DW'(bus.ready_pk), '0);
        check("ready_c after drain", DW'(bus.ready_c), '0);
        bus.req = 1'b0;
        tick();
        check("valid after drain", DW'(bus.valid), '0);
        check("dout hold after drain", bus.dout, base + DW'(len - 1));
        bus.req = 1'b1;
        tick();
        check("req ignored in idle", DW'(bus.valid), '0);
        bus.req = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] base;

        vecs[0] = '{1'b0, 3'd4, 1'b0, 1'b0, 392};
        vecs[1] = '{1'b1, 3'd2, 1'b1, 1'b0, 192};
        vecs[2] = '{1'b0, 3'd5, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b0, 3'd3, 1'b0, 1'b0, 296};
        vecs[4] = '{1'b1, 3'd3, 1'b1, 1'b0, 272};
        vecs[5] = '{1'b0, 3'd2, 1'b0, 1'b0, 200};
        vecs[6] = '{1'b1, 3'd4, 1'b0, 1'b0, 392};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 1'b1, 0};
        vecs[8] = '{1'b1, 3'd1, 1'b0, 1'b1, 0};
        vecs[9] = '{1'b0, 3'd7, 1'b0, 1'b1, 0};

        rst = 1'b1;
        bus.start = 1'b0; bus.sel = 1'b0; bus.k = 3'd0;
        bus.wen = 1'b0; bus.din = '0; bus.req = 1'b0;
        repeat (3) tick();
        check("reset ready_pk", DW'(bus.ready_pk), '0);
        check("reset ready_c", DW'(bus.ready_c), '0);
        check("reset valid", DW'(bus.valid), '0);
        check("reset err", DW'(bus.err), '0);
        check("reset dout", bus.dout, '0);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 10; r++) begin
            base = 32'hA000_0000 + (DW'(r) << 16);
            start_frame(vecs[r].sel, vecs[r].k);
            check("err after start", DW'(bus.err), DW'(vecs[r].exp_err));
            if (vecs[r].exp_err) begin
                tick();
                check("err pulse width", DW'(bus.err), '0);
                check("no ready_pk on bad k", DW'(bus.ready_pk), '0);
                check("no ready_c on bad k", DW'(bus.ready_c), '0);
                // Still in IDLE: a write strobe must be flagged as stray.
                bus.wen = 1'b1;
                tick();
                bus.wen = 1'b0;
                check("stray wen in idle", DW'(bus.err), DW'(1));
                tick();
                check("stray err width", DW'(bus.err), '0);
            end else begin
                write_frame(vecs[r].exp_len, base, vecs[r].gaps, vecs[r].sel);
                drain(vecs[r].exp_len, base, -1);
            end
        end

        // Extra word while holding a complete frame.
        base = 32'hB000_0000;
        start_frame(1'b0, 3'd2);
        write_frame(200, base, 1'b0, 1'b0);
        bus.wen = 1'b1;
        bus.din = 32'hDEAD_BEEF;
        tick();
        bus.wen = 1'b0;
        check("stray wen in hold", DW'(bus.err), DW'(1));
        check("ready_pk kept in hold", DW'(bus.ready_pk), DW'(1));
        tick();
        check("hold err width", DW'(bus.err), '0);
        drain(200, base, -1);

        // Reset after word 100 of a k=3 pk frame, with competing inputs.
        base = 32'hC000_0000;
        start_frame(1'b0, 3'd3);
        for (int i = 0; i <= 100; i++) begin
            bus.wen = 1'b1;
            bus.din = base + DW'(i);
            if (i == 50) begin
                bus.start = 1'b1;
                bus.k     = 3'd5;
            end
            tick();
            bus.start = 1'b0;
            if (i == 50) check("start ignored in recv", DW'(bus.err), '0);
        end
        rst = 1'b1;
        bus.start = 1'b1; bus.sel = 1'b0; bus.k = 3'd3;
        bus.req = 1'b1;
        tick();
        check("mid reset ready_pk", DW'(bus.ready_pk), '0);
        check("mid reset ready_c", DW'(bus.ready_c), '0);
        check("mid reset valid", DW'(bus.valid), '0);
        check("mid reset err", DW'(bus.err), '0);
        check("mid reset dout", bus.dout, '0);
        rst = 1'b0;
        bus.start = 1'b0; bus.req = 1'b0;
        tick();
        check("reset beat start", DW'(bus.err), DW'(1));
        bus.wen = 1'b0;
        tick();
        base = 32'hC100_0000;
        start_frame(1'b0, 3'd3);
        write_frame(296, base, 1'b0, 1'b0);
        drain(296, base, -1);

        // Requests during RECV are ignored; consumer stalls mid-drain.
        base = 32'hD000_0000;
        start_frame(1'b1, 3'd2);
        bus.req = 1'b1;
        repeat (3) begin
            tick();
            check("req ignored in recv", DW'(bus.valid), '0);
        end
        bus.req = 1'b0;
        write_frame(192, base, 1'b0, 1'b1);
        drain(192, base, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/kyber_frame_rx.md
KYBER_FRAME_RX -- requirements
Module: kyber_frame_rx

Interface
REQ-001 SHALL have parameter DW, default 32, meaning link word width in bits.
REQ-002 SHALL have parameter AW, default 9, meaning buffer address width (512 words).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that arms reception of one frame.
REQ-006 SHALL have port sel  input  1  frame type sampled with start: 0 = public key (pk), 1 = ciphertext (c).
REQ-007 SHALL have port k  input  3  security parameter sampled with start; legal values 2, 3, 4.
REQ-008 SHALL have port wen  input  1  write strobe from the peer's valid output.
REQ-009 SHALL have port din  input  DW  link word from the peer's dout output.
REQ-010 SHALL have port ready_pk  output  1  complete pk frame buffered.
REQ-011 SHALL have port ready_c  output  1  complete ciphertext frame buffered.
REQ-012 SHALL have port req  input  1  consumer read request, one word per cycle.
REQ-013 SHALL have port valid  output  1  dout carries a buffered word this cycle.
REQ-014 SHALL have port dout  output  DW  buffered word, in arrival order.
REQ-015 SHALL have port err  output  1  single-cycle pulse on illegal k at start or on a stray wen.

Function
REQ-016 SHALL implement states IDLE, RECV, HOLD, DRAIN.
REQ-017 SHALL, on start in IDLE with legal k, latch sel and frame length LEN and enter RECV with write and read counters at 0.
REQ-018 SHALL use LEN for pk: k=2 -> 200, k=3 -> 296, k=4 -> 392 words.
REQ-019 SHALL use LEN for c: k=2 -> 192, k=3 -> 272, k=4 -> 392 words.
REQ-020 SHALL, on start in IDLE with illegal k (0, 1, 5-7), pulse err the next cycle and remain in IDLE.
REQ-021 SHALL ignore start in any state other than IDLE.
REQ-022 SHALL, in RECV, write din to buffer[wr_cnt] and increment wr_cnt on every cycle wen=1; no back-pressure.
REQ-023 SHALL, when the write of word LEN-1 occurs, enter HOLD on the next edge.
REQ-024 SHALL, in HOLD and DRAIN, drive ready_pk = (sel=0) and ready_c = (sel=1); both SHALL be 0 in all other states.
REQ-025 SHALL, on wen in IDLE, HOLD or DRAIN, discard the word and pulse err one cycle later.
REQ-026 SHALL ignore wen on the same cycle as an accepted start.
REQ-027 SHALL, on req in HOLD or DRAIN, read buffer[rd_cnt], increment rd_cnt, and assert valid with that word on dout exactly one cycle later.
REQ-028 SHALL enter DRAIN on the first accepted req.
REQ-029 SHALL return to IDLE on the edge after the req that reads word LEN-1; ready drops that same edge; the final valid follows one cycle later.
REQ-030 SHALL ignore req in IDLE and RECV; valid SHALL stay 0.
REQ-031 SHALL hold dout at its last value when valid=0.
REQ-032 SHALL size counters to AW bits; LEN never exceeds 392, so there is no wrap-around.
REQ-033 SHALL implement the buffer as a single-port-write, single-port-read synchronous RAM of 2^AW x DW.

Reset
REQ-034 SHALL, while rst=1, force state IDLE, counters 0, and ready_pk, ready_c, valid, err, dout all 0; buffer contents need not be cleared.
REQ-035 SHALL give rst priority over start, wen and req on the same cycle.
REQ-036 SHALL, on reset mid-frame, abandon the frame; a subsequent start SHALL begin a fresh frame at word 0.

Verification
REQ-037 SHALL cover: start, sel=0, k=4; 392 wen words 0..391 -> ready_pk=1 one cycle after last write; 392 req cycles -> valid words 0..391 in order; IDLE afterwards.
REQ-038 SHALL cover: start, sel=1, k=2; 192 words with random wen gaps -> ready_c=1, ready_pk=0; drain output equals input.
REQ-039 SHALL cover: start, k=5 -> err pulse one cycle later, no ready, state IDLE; following start with k=3, sel=0 -> frame length 296.
REQ-040 SHALL cover: extra wen word during HOLD -> err pulse, word discarded, drained data unchanged.
REQ-041 SHALL cover: rst asserted after word 100 of a k=3 pk frame -> all outputs 0; new start -> full 296-word frame received correctly.
REQ-042 SHALL cover: req stalls during drain (req low 5 cycles mid-frame) -> valid low during the stall, no word lost or duplicated.
